trivium_decrypt: RTL and testbench
==================================

# trivium_decrypt

Trivium stream-cipher decryptor. It is the receive-side counterpart of the 288-bit-state Trivium encryptor.
- Loads an 80-bit key and 80-bit IV, then runs the 1152-round warm-up.
- XORs incoming ciphertext words with the generated keystream to recover plaintext, W bits per clock.
- Sits between the link deframer (ciphertext source) and the payload consumer (plaintext sink), using valid/ready handshakes on both sides.

## Interface
- W, default 8: keystream bits per clock. Legal values are 1, 2, 4, 8, 16, 32 and 64; each divides 1152.
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low; reset is applied when reset==0 at a rising edge.
- start  input  1  one-cycle pulse; samples key/iv and begins warm-up; honoured in any state.
- key  input  80  key bits; key[i-1] = K_i.
- iv  input  80  IV bits; iv[i-1] = IV_i.
- busy  output  1  high during warm-up (INIT).
- ks_ready  output  1  high in RUN (keystream available).
- ct_valid  input  1  ciphertext word valid.
- ct_ready  output  1  block accepts ciphertext this cycle.
- ct_data  input  W  ciphertext word; bit 0 is the earliest stream bit.
- pt_valid  output  1  plaintext word valid.
- pt_ready  input  1  sink accepts plaintext.
- pt_data  output  W  plaintext word; bit 0 is the earliest stream bit.
- state_o  output  288  cipher state, state_o[i-1] = s_i, for debug and bench comparison.

## Operation
- FSM states: IDLE, INIT and RUN.
- Load (on start): state_o[79:0]=key, state_o[92:80]=0, state_o[172:93]=iv, state_o[284:173]=0, state_o[287:285]=3'b111.
- One round:
  - t1=s66^s93, t2=s162^s177, t3=s243^s288, z=t1^t2^t3.
  - t1^=s91&s92^s171, t2^=s175&s176^s264, t3^=s286&s287^s69.
  - Shift: s1..s93 ← (t3,s1..s92); s94..s177 ← (t1,s94..s176); s178..s288 ← (t2,s178..s287).
- W rounds are unrolled per clock. Round j (j=0 first) produces z_j, and pt_data[j] = ct_data[j]^z_j.
- IDLE: state holds; ct_ready=0. start → load, go to INIT.
- INIT:
  - A down-counter is loaded with N-1, where N=1152/W.
  - Each cycle advances W rounds and discards z.
  - At count 0 the state advances and the FSM goes to RUN.
- RUN:
  - ct_ready = !pt_valid || pt_ready.
  - On a ct handshake, the state advances W rounds and pt_data/pt_valid are registered.
  - With no handshake, the state holds; the keystream never advances without a consumed word.
- pt_valid clears on a pt handshake that has no simultaneous ct handshake. Simultaneous pt and ct handshakes refresh pt_data and keep pt_valid=1.
- start during INIT or RUN:
  - Reload key/iv and restart INIT.
  - pt_valid is cleared next cycle and a pending plaintext word is dropped.
  - A ct word offered in that cycle is not accepted (ct_ready forced 0 when start=1).
- Reset (reset==0) wins over start.

## Timing
- Reset values:
  - FSM is IDLE; state_o=0; counter=0.
  - busy=0, ks_ready=0, ct_ready=0, pt_valid=0, pt_data=0.
- start sampled at edge E0. From the cycle after E0:
  - busy=1 and state_o shows the load pattern.
  - Keystream availability is N+1 cycles after E0: ks_ready=1, busy=0 from cycle N+1 after E0 (W=8: 145; W=1: 1153).
- ct → pt latency: 1 cycle. Plaintext is registered; no combinational path from ct_data to pt_data.
- Throughput: one W-bit word per cycle while pt_ready stays high.
- pt_data and pt_valid are stable while pt_valid=1 and pt_ready=0.
- Reset asserted mid-INIT or mid-RUN takes effect at that edge and forces all reset values.

## Test plan
- Reset: hold reset=0 three cycles with start=1, ct_valid=1 → all outputs 0, FSM idle, state_o=0.
- Load/warm-up (W=8): key=0, iv=80'h0000123456789abcdef, start pulse → next cycle state_o[172:93]=iv, state_o[287:285]=3'b111, busy=1. ks_ready rises exactly 145 cycles after the start edge; state_o then matches a golden model after 1152 rounds.
- Round trip: bench encryptor model with the same key/iv encrypts 512 bytes; stream them with random ct_valid/pt_ready → pt_data equals the original bytes, with no loss or duplication.
- Backpressure: pt_ready=0 for 10 cycles with ct_valid=1 → exactly one word accepted, then ct_ready=0. pt_data is held constant, and the keystream does not advance (state_o constant).
- Rekey mid-stream: start after 5 words with a new key → pt_valid=0 next cycle, busy=1. ks_ready returns 145 cycles later, and output matches the golden model for the new key from its first bit.
- Reset mid-INIT at cycle 60 → all outputs return to reset values; a following start gives a normal 145-cycle warm-up.

Source files
------------

// File: rtl/trivium_decrypt.sv
// Trivium stream-cipher decryptor: key/IV load, 1152-round warm-up, then
// W keystream bits per clock XORed onto ciphertext through valid/ready handshakes.
module trivium_decrypt #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [79:0]    key,
    input  logic [79:0]    iv,
    output logic           busy,
    output logic           ks_ready,
    input  logic           ct_valid,
    output logic           ct_ready,
    input  logic [W-1:0]   ct_data,
    output logic           pt_valid,
    input  logic           pt_ready,
    output logic [W-1:0]   pt_data,
    output logic [287:0]   state_o
);

    localparam int unsigned N = 1152 / W;

    typedef enum logic [1:0] {IDLE, INIT, RUN} fsm_t;

    fsm_t         fsm;
    logic [10:0]  cnt;
    logic [287:0] s;
    logic [287:0] s_next;
    logic [W-1:0] z;
    logic         ct_hs;

    // W rounds unrolled; bit s_i lives at s[i-1], round j yields z[j].
    always_comb begin
        logic t1;
        logic t2;
        logic t3;
        s_next = s;
        z      = '0;
        t1     = 1'b0;
        t2     = 1'b0;
        t3     = 1'b0;
        for (int unsigned j = 0; j < W; j++) begin
            t1   = s_next[65] ^ s_next[92];
            t2   = s_next[161] ^ s_next[176];
            t3   = s_next[242] ^ s_next[287];
            z[j] = t1 ^ t2 ^ t3;
            t1   = t1 ^ (s_next[90] & s_next[91]) ^ s_next[170];
            t2   = t2 ^ (s_next[174] & s_next[175]) ^ s_next[263];
            t3   = t3 ^ (s_next[285] & s_next[286]) ^ s_next[68];
            s_next = {s_next[286:177], t2, s_next[175:93], t1, s_next[91:0], t3};
        end
    end

    assign ct_ready = ks_ready && !start && (!pt_valid || pt_ready);
    assign ct_hs    = ct_valid && ct_ready;
    assign state_o  = s;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm      <= IDLE;
            s        <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            ks_ready <= 1'b0;
            pt_valid <= 1'b0;
            pt_data  <= '0;
        end else if (start) begin
            fsm      <= INIT;
            s        <= {3'b111, 112'b0, iv, 13'b0, key};
            cnt      <= 11'(N - 1);
            busy     <= 1'b1;
            ks_ready <= 1'b0;
            pt_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: ;
                INIT: begin
                    s <= s_next;
                    if (cnt == '0) begin
                        fsm      <= RUN;
                        busy     <= 1'b0;
                        ks_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 11'd1;
                    end
                end
                RUN: begin
                    // keystream only advances when a ciphertext word is consumed
                    if (ct_hs) begin
                        s        <= s_next;
                        pt_data  <= ct_data ^ z;
                        pt_valid <= 1'b1;
                    end else if (pt_ready) begin
                        pt_valid <= 1'b0;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trivium_decrypt.sv
// Scoreboard bench for trivium_decrypt: a bit-array Trivium model predicts every
// plaintext word; a monitor compares words as the sink accepts them.
module tb_trivium_decrypt;

    localparam int unsigned W = 8;
    localparam int unsigned N = 1152 / W;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [79:0]    key = '0;
    logic [79:0]    iv = '0;
    logic           busy;
    logic           ks_ready;
    logic           ct_valid = 1'b0;
    logic           ct_ready;
    logic [W-1:0]   ct_data = '0;
    logic           pt_valid;
    logic           pt_ready = 1'b0;
    logic [W-1:0]   pt_data;
    logic [287:0]   state_o;

    trivium_decrypt #(.W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .key(key), .iv(iv),
        .busy(busy), .ks_ready(ks_ready),
        .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit m [1:288];
    logic [W-1:0] sb [$];
    int ct_sent = 0;
    int pt_got = 0;
    logic [W-1:0] rx [0:1023];

    task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_load(input logic [79:0] k, input logic [79:0] v);
        for (int unsigned i = 1; i <= 288; i++) m[i] = 1'b0;
        for (int unsigned i = 1; i <= 80; i++) begin
            m[i]      = k[i-1];
            m[93 + i] = v[i-1];
        end
        m[286] = 1'b1;
        m[287] = 1'b1;
        m[288] = 1'b1;
    endfunction

    function automatic logic [287:0] model_state();
        logic [287:0] r;
        for (int unsigned i = 1; i <= 288; i++) r[i-1] = m[i];
        return r;
    endfunction

    // W rounds straight from the round equations; returns z_0..z_{W-1}
    function automatic logic [W-1:0] model_word();
        logic [W-1:0] zw;
        bit t1, t2, t3;
        for (int unsigned j = 0; j < W; j++) begin
            t1 = m[66] ^ m[93];
            t2 = m[162] ^ m[177];
            t3 = m[243] ^ m[288];
            zw[j] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (m[91] & m[92]) ^ m[171];
            t2 = t2 ^ (m[175] & m[176]) ^ m[264];
            t3 = t3 ^ (m[286] & m[287]) ^ m[69];
            for (int unsigned i = 93; i > 1; i--) m[i] = m[i-1];
            m[1] = t3;
            for (int unsigned i = 177; i > 94; i--) m[i] = m[i-1];
            m[94] = t1;
            for (int unsigned i = 288; i > 178; i--) m[i] = m[i-1];
            m[178] = t2;
        end
        return zw;
    endfunction

    function automatic void model_warm();
        logic [W-1:0] d;
        for (int unsigned i = 0; i < N; i++) d = model_word();
    endfunction

    // ciphertext side: every accepted word queues its predicted plaintext
    always @(negedge clk) begin
        if (reset && ct_valid && ct_ready) begin
            sb.push_back(ct_data ^ model_word());
            ct_sent++;
        end
    end

    // plaintext side: compare every word the sink accepts
    always @(negedge clk) begin
        if (reset && pt_valid && pt_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: got %h expected no word", pt_data);
            end else begin
                check("pt_data", pt_data, sb.pop_front());
            end
            if (pt_got < 1024) rx[pt_got] = pt_data;
            pt_got++;
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // called one step after the start edge (cycle 1)
    task automatic wait_ready(output int cyc);
        cyc = 1;
        while (!ks_ready && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ks_ready"}, ks_ready, 0);
        check({tag, "_ct_ready"}, ct_ready, 0);
        check({tag, "_pt_valid"}, pt_valid, 0);
        check({tag, "_pt_data"}, pt_data, 0);
        check({tag, "_state"}, state_o, 0);
    endtask

    task automatic drain();
        int cyc = 0;
        ct_valid = 1'b0;
        pt_ready = 1'b1;
        while ((sb.size() != 0 || pt_valid) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("drain_sb_empty", sb.size(), 0);
    endtask

    task automatic stream(input int n);
        int base = ct_sent;
        int cyc = 0;
        while (ct_sent - base < n && cyc < 20 * n) begin
            ct_valid = ($urandom % 4) != 0;
            ct_data  = W'($urandom);
            pt_ready = ($urandom % 4) != 0;
            @(posedge clk); #1;
            cyc++;
        end
        ct_valid = 1'b0;
        check("stream_sent", ct_sent - base, n);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    logic [W-1:0] p   [512];
    logic [W-1:0] enc [512];
    bit save [1:288];

    initial begin
        int cyc;
        int base;
        int errs;
        logic [W-1:0] pd;
        logic [287:0] sd;
        logic [79:0] key2;
        logic [79:0] iv2;

        // reset dominates start and ciphertext
        reset = 1'b0; start = 1'b1; ct_valid = 1'b1; pt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        reset = 1'b1; start = 1'b0; ct_valid = 1'b0;
        @(posedge clk); #1;
        check("idle_state", state_o, 0);
        check("idle_busy", busy, 0);

        // load and warm-up
        key = '0;
        iv  = 80'h0000123456789abcdef;
        do_start();
        model_load(key, iv);
        check("load_state", state_o, model_state());
        check("load_iv", state_o[172:93], iv);
        check("load_top", state_o[287:285], 3'b111);
        check("load_busy", busy, 1);
        wait_ready(cyc);
        check("warm_cycles", cyc, N + 1);
        check("warm_busy", busy, 0);
        model_warm();
        check("warm_state", state_o, model_state());

        // round trip through an independent encryption of random bytes
        save = m;
        for (int i = 0; i < 512; i++) begin
            p[i]   = W'($urandom);
            enc[i] = p[i] ^ model_word();
        end
        m = save;
        pt_got = 0;
        base = ct_sent;
        cyc = 0;
        while (ct_sent - base < 512 && cyc < 5000) begin
            ct_valid = ($urandom % 4) != 0;
            ct_data  = enc[ct_sent - base];
            pt_ready = ($urandom % 4) != 0;
            @(posedge clk); #1;
            cyc++;
        end
        ct_valid = 1'b0;
        drain();
        check("rt_count", pt_got, 512);
        errs = 0;
        for (int i = 0; i < 512; i++) if (rx[i] !== p[i]) errs++;
        check("rt_data_errors", errs, 0);
        check("rt_state", state_o, model_state());

        // backpressure: one word in, then stall with state frozen
        pt_ready = 1'b0;
        ct_valid = 1'b1;
        ct_data  = W'($urandom);
        base = ct_sent;
        @(posedge clk); #1;
        pd = pt_data;
        sd = state_o;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("bp_accepted", ct_sent - base, 1);
        check("bp_ct_ready", ct_ready, 0);
        check("bp_pt_valid", pt_valid, 1);
        check("bp_pt_hold", pt_data, pd);
        check("bp_state_hold", state_o, sd);
        check("bp_state_model", state_o, model_state());
        drain();

        // rekey after five words, with one plaintext word left pending
        base = ct_sent;
        ct_valid = 1'b1;
        pt_ready = 1'b1;
        cyc = 0;
        while (ct_sent - base < 5 && cyc < 100) begin
            ct_data = W'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        check("rk_words", ct_sent - base, 5);
        key2 = {$urandom, $urandom, 16'($urandom)};
        iv2  = {$urandom, $urandom, 16'($urandom)};
        key = key2;
        iv  = iv2;
        start = 1'b1;
        pt_ready = 1'b0;
        ct_data = W'($urandom);
        @(negedge clk);
        check("rk_ct_ready", ct_ready, 0);
        check("rk_pending", pt_valid, 1);
        @(posedge clk); #1;
        start = 1'b0;
        ct_valid = 1'b0;
        check("rk_pt_valid", pt_valid, 0);
        check("rk_busy", busy, 1);
        sb.delete();
        model_load(key2, iv2);
        wait_ready(cyc);
        check("rk_warm_cycles", cyc, N + 1);
        model_warm();
        check("rk_warm_state", state_o, model_state());
        stream(64);

        // reset in the middle of warm-up, then a clean restart
        do_start();
        repeat (59) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_values("mid");
        reset = 1'b1;
        @(posedge clk); #1;
        do_start();
        model_load(key2, iv2);
        check("re_load_state", state_o, model_state());
        wait_ready(cyc);
        check("re_warm_cycles", cyc, N + 1);
        model_warm();
        check("re_warm_state", state_o, model_state());
        stream(32);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
